// File: rtl/immu_resp.sv
// rtl/immu_resp.sv - instruction-fetch MMU front end: DMW translation, fetch exception flags, one-or-two-word ibus read sequencer
module immu_resp (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mmu_i_req,
    input  logic [31:0] mmu_i_addr,
    output logic        mmu_i_addr_ok,
    output logic        mmu_i_double,
    output logic        mmu_i_data_ok,
    output logic [63:0] mmu_i_rdata,
    output logic        mmu_i_tlbr,
    output logic        mmu_i_pif,
    output logic        mmu_i_ppi,
    input  logic        csr_da,
    input  logic        csr_pg,
    input  logic [1:0]  csr_plv,
    input  logic [31:0] csr_dmw0,
    input  logic [31:0] csr_dmw1,
    output logic        ibus_req,
    output logic [31:0] ibus_addr,
    input  logic        ibus_addr_ok,
    input  logic        ibus_data_ok,
    input  logic [31:0] ibus_rdata
);

    typedef enum logic [2:0] {S_IDLE, S_A0, S_D0, S_A1, S_D1, S_RESP} state_t;

    state_t      state_q, state_d;
    logic [31:0] pa_q, pa_d;
    logic        double_q, double_d;
    logic [63:0] rdata_q, rdata_d;

    logic        paged, hit0, hit1, use0, use1, accept;
    logic [3:0]  plv_en0, plv_en1;
    logic [31:0] pa;
    logic        unused_csr;

    // Anything other than direct mode is treated as paged; only the DMW windows map.
    assign paged   = !csr_da;
    assign plv_en0 = csr_dmw0[3:0];
    assign plv_en1 = csr_dmw1[3:0];
    assign hit0    = (csr_dmw0[31:29] == mmu_i_addr[31:29]);
    assign hit1    = (csr_dmw1[31:29] == mmu_i_addr[31:29]);
    assign use0    = hit0 && plv_en0[csr_plv];
    assign use1    = hit1 && plv_en1[csr_plv];

    assign mmu_i_tlbr = paged && !hit0 && !hit1;
    assign mmu_i_ppi  = paged && (hit0 || hit1) && !use0 && !use1;
    assign mmu_i_pif  = 1'b0;

    assign pa = !paged ? mmu_i_addr :
                use0   ? {csr_dmw0[27:25], mmu_i_addr[28:0]} :
                use1   ? {csr_dmw1[27:25], mmu_i_addr[28:0]} :
                         mmu_i_addr;

    assign unused_csr = ^{csr_pg, csr_dmw0[28], csr_dmw0[24:4], csr_dmw1[28], csr_dmw1[24:4]};

    assign mmu_i_double  = !mmu_i_addr[2];
    assign mmu_i_addr_ok = ((state_q == S_IDLE) || (state_q == S_RESP)) &&
                           !(mmu_i_tlbr || mmu_i_ppi || mmu_i_pif);
    assign accept        = mmu_i_req && mmu_i_addr_ok;
    assign mmu_i_rdata   = rdata_q;

    always_comb begin
        state_d       = state_q;
        pa_d          = pa_q;
        double_d      = double_q;
        rdata_d       = rdata_q;
        ibus_req      = 1'b0;
        ibus_addr     = 32'h0;
        mmu_i_data_ok = 1'b0;
        case (state_q)
            S_IDLE: state_d = S_IDLE;
            S_A0: begin
                ibus_req  = 1'b1;
                ibus_addr = pa_q;
                if (ibus_addr_ok) state_d = S_D0;
            end
            S_D0: begin
                if (ibus_data_ok) begin
                    rdata_d[31:0] = ibus_rdata;
                    state_d       = double_q ? S_A1 : S_RESP;
                end
            end
            S_A1: begin
                ibus_req  = 1'b1;
                ibus_addr = pa_q + 32'd4;
                if (ibus_addr_ok) state_d = S_D1;
            end
            S_D1: begin
                if (ibus_data_ok) begin
                    rdata_d[63:32] = ibus_rdata;
                    state_d        = S_RESP;
                end
            end
            S_RESP: begin
                mmu_i_data_ok = 1'b1;
                state_d       = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // accept is only possible in IDLE/RESP, so this overrides their next state
        if (accept) begin
            state_d  = S_A0;
            pa_d     = pa;
            double_d = !mmu_i_addr[2];
            if (mmu_i_addr[2]) rdata_d[63:32] = 32'h0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            pa_q     <= 32'h0;
            double_q <= 1'b0;
            rdata_q  <= 64'h0;
        end else begin
            state_q  <= state_d;
            pa_q     <= pa_d;
            double_q <= double_d;
            rdata_q  <= rdata_d;
        end
    end

endmodule

// File: tb/tb_immu_resp.sv
// tb/tb_immu_resp.sv - scoreboard bench for immu_resp with a programmable-stall ibus responder
module tb_immu_resp;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        mmu_i_req = 1'b0;
    logic [31:0] mmu_i_addr = 32'h0;
    logic        mmu_i_addr_ok, mmu_i_double, mmu_i_data_ok;
    logic [63:0] mmu_i_rdata;
    logic        mmu_i_tlbr, mmu_i_pif, mmu_i_ppi;
    logic        csr_da = 1'b1, csr_pg = 1'b0;
    logic [1:0]  csr_plv = 2'd0;
    logic [31:0] csr_dmw0 = 32'h0, csr_dmw1 = 32'h0;
    logic        ibus_req;
    logic [31:0] ibus_addr;
    logic        ibus_addr_ok = 1'b0, ibus_data_ok = 1'b0;
    logic [31:0] ibus_rdata = 32'h0;

    immu_resp dut (
        .clk(clk), .resetn(resetn),
        .mmu_i_req(mmu_i_req), .mmu_i_addr(mmu_i_addr),
        .mmu_i_addr_ok(mmu_i_addr_ok), .mmu_i_double(mmu_i_double),
        .mmu_i_data_ok(mmu_i_data_ok), .mmu_i_rdata(mmu_i_rdata),
        .mmu_i_tlbr(mmu_i_tlbr), .mmu_i_pif(mmu_i_pif), .mmu_i_ppi(mmu_i_ppi),
        .csr_da(csr_da), .csr_pg(csr_pg), .csr_plv(csr_plv),
        .csr_dmw0(csr_dmw0), .csr_dmw1(csr_dmw1),
        .ibus_req(ibus_req), .ibus_addr(ibus_addr),
        .ibus_addr_ok(ibus_addr_ok), .ibus_data_ok(ibus_data_ok), .ibus_rdata(ibus_rdata)
    );

    typedef struct { logic [63:0] rdata; int due; } sb_t;
    typedef struct { logic [31:0] addr; logic [31:0] word; int stall; } beat_t;

    sb_t   sb[$];
    beat_t beats[$];
    int    cyc = 0;
    int    n_chk = 0;
    int    n_pass = 0;
    bit    stray_pulse = 1'b0;

    initial forever #5 clk = ~clk;
    initial forever begin @(posedge clk); cyc++; end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // ibus slave: per-beat addr_ok stall from the beat queue, data_ok the cycle after addr_ok
    initial begin
        bit          pend;
        logic [31:0] word;
        int          stalled;
        pend = 1'b0; word = 32'h0; stalled = 0;
        forever begin
            @(negedge clk);
            ibus_addr_ok = 1'b0;
            ibus_data_ok = 1'b0;
            if (stray_pulse) begin
                ibus_data_ok = 1'b1;
                ibus_rdata   = 32'hbad0bad0;
                stray_pulse  = 1'b0;
            end else if (pend) begin
                ibus_data_ok = 1'b1;
                ibus_rdata   = word;
                pend         = 1'b0;
            end else if (ibus_req) begin
                if (beats.size() == 0) begin
                    chk("ibus_req_unexpected", {63'h0, ibus_req}, 64'h0);
                end else begin
                    chk("ibus_addr", {32'h0, ibus_addr}, {32'h0, beats[0].addr});
                    if (stalled < beats[0].stall) begin
                        stalled++;
                    end else begin
                        stalled      = 0;
                        ibus_addr_ok = 1'b1;
                        word         = beats[0].word;
                        void'(beats.pop_front());
                        pend         = 1'b1;
                    end
                end
            end
        end
    end

    // response monitor
    initial begin
        sb_t e;
        forever begin
            @(negedge clk);
            if (resetn && mmu_i_data_ok) begin
                if (sb.size() == 0) begin
                    chk("data_ok_unexpected", {63'h0, mmu_i_data_ok}, 64'h0);
                end else begin
                    e = sb.pop_front();
                    chk("rdata", mmu_i_rdata, e.rdata);
                    chk("latency", 64'(cyc), 64'(e.due));
                end
            end
        end
    end

    // Called at negedge+2; returns at negedge+2 of the cycle after the accept.
    task automatic fetch(input logic [31:0] va, input logic [31:0] pa, input bit dbl,
                         input logic [31:0] w0, input logic [31:0] w1, input int stall,
                         input bit hold, output int acc);
        beat_t b;
        sb_t   e;
        int    n;
        b.addr = pa; b.word = w0; b.stall = stall;
        beats.push_back(b);
        if (dbl) begin
            b.addr = pa + 32'd4; b.word = w1; b.stall = 0;
            beats.push_back(b);
        end
        mmu_i_req  = 1'b1;
        mmu_i_addr = va;
        #1;
        chk("double", {63'h0, mmu_i_double}, {63'h0, dbl});
        n = 0;
        while (!mmu_i_addr_ok && n < 50) begin
            @(negedge clk); #3;
            n++;
        end
        chk("accept", {63'h0, mmu_i_addr_ok}, 64'h1);
        acc     = cyc;
        e.rdata = dbl ? {w1, w0} : {32'h0, w0};
        e.due   = cyc + (dbl ? 5 : 3) + stall;
        sb.push_back(e);
        @(negedge clk); #2;
        if (!hold) mmu_i_req = 1'b0;
    endtask

    task automatic exc(input logic [31:0] va, input bit tl, input bit pp);
        mmu_i_req  = 1'b1;
        mmu_i_addr = va;
        #1;
        chk("tlbr", {63'h0, mmu_i_tlbr}, {63'h0, tl});
        chk("ppi",  {63'h0, mmu_i_ppi},  {63'h0, pp});
        chk("pif",  {63'h0, mmu_i_pif},  64'h0);
        repeat (3) @(negedge clk);
        #2;
        chk("exc_addr_ok", {63'h0, mmu_i_addr_ok}, 64'h0);
        mmu_i_req = 1'b0;
        #1;
        chk("tlbr_no_req", {63'h0, mmu_i_tlbr}, {63'h0, tl});
        @(negedge clk); #2;
    endtask

    initial begin
        int a1, a2, a3, n, cnt;
        @(negedge clk);
        chk("rst_data_ok",  {63'h0, mmu_i_data_ok}, 64'h0);
        chk("rst_rdata",    mmu_i_rdata, 64'h0);
        chk("rst_ibus_req", {63'h0, ibus_req}, 64'h0);
        #2 resetn = 1'b1;
        @(negedge clk); #2;

        fetch(32'h1c000000, 32'h1c000000, 1'b1, 32'h11111111, 32'h22222222, 0, 1'b0, a1);
        repeat (6) @(negedge clk);
        #2;
        fetch(32'h1c000004, 32'h1c000004, 1'b0, 32'h33333333, 32'h0, 0, 1'b0, a1);
        repeat (4) @(negedge clk);
        #2;
        fetch(32'h1c000104, 32'h1c000104, 1'b0, 32'h44444444, 32'h0, 4, 1'b0, a1);
        repeat (9) @(negedge clk);
        #2;
        fetch(32'hfffffff8, 32'hfffffff8, 1'b1, 32'h55555555, 32'h66666666, 0, 1'b0, a1);
        repeat (6) @(negedge clk);
        #2;

        csr_da = 1'b0; csr_pg = 1'b1; csr_plv = 2'd0;
        csr_dmw0 = 32'ha0000001; csr_dmw1 = 32'h0;
        fetch(32'ha0001000, 32'h00001000, 1'b1, 32'h77777777, 32'h88888888, 0, 1'b0, a1);
        repeat (6) @(negedge clk);
        #2;
        csr_dmw0 = 32'ha0000008;
        exc(32'ha0001000, 1'b0, 1'b1);
        csr_dmw0 = 32'ha0000001;
        exc(32'h40000000, 1'b1, 1'b0);
        csr_dmw1 = 32'h8a000001;
        fetch(32'h80000014, 32'ha0000014, 1'b0, 32'h99999999, 32'h0, 0, 1'b0, a1);
        repeat (4) @(negedge clk);
        #2;

        csr_da = 1'b1; csr_pg = 1'b0;
        fetch(32'h1c000204, 32'h1c000204, 1'b0, 32'haaaa0001, 32'h0, 0, 1'b1, a1);
        fetch(32'h1c000300, 32'h1c000300, 1'b1, 32'haaaa0002, 32'haaaa0003, 0, 1'b1, a2);
        fetch(32'h1c000404, 32'h1c000404, 1'b0, 32'haaaa0004, 32'h0, 0, 1'b0, a3);
        chk("b2b_gap1", 64'(a2 - a1), 64'd3);
        chk("b2b_gap2", 64'(a3 - a2), 64'd5);
        repeat (4) @(negedge clk);
        #2;

        fetch(32'h1c000500, 32'h1c000500, 1'b1, 32'hcccc0001, 32'hcccc0002, 0, 1'b0, a1);
        repeat (3) @(negedge clk);
        #2;
        resetn = 1'b0;
        #1;
        chk("midrst_data_ok",  {63'h0, mmu_i_data_ok}, 64'h0);
        chk("midrst_rdata",    mmu_i_rdata, 64'h0);
        chk("midrst_ibus_req", {63'h0, ibus_req}, 64'h0);
        sb.delete();
        @(negedge clk); #2;
        stray_pulse = 1'b1;
        resetn      = 1'b1;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); #1;
            if (mmu_i_data_ok) cnt++;
        end
        chk("stray_data_ok_count", 64'(cnt), 64'd0);
        #1;

        fetch(32'h1c000604, 32'h1c000604, 1'b0, 32'hdddd0001, 32'h0, 0, 1'b0, a1);
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        #2;
        chk("drain", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/immu_resp.md
IMMU_RESP -- requirements
Module: immu_resp

Interface
REQ-001 SHALL: clk  input  1  single clock; all state on rising edge.
REQ-002 SHALL: resetn  input  1  asynchronous, active-low reset.
REQ-003 SHALL: mmu_i_req  input  1  fetch request from fetch unit.
REQ-004 SHALL: mmu_i_addr  input  32  fetch virtual address.
REQ-005 SHALL: mmu_i_addr_ok  output  1  request accepted this cycle (combinational).
REQ-006 SHALL: mmu_i_double  output  1  fetch returns two instructions (combinational on mmu_i_addr).
REQ-007 SHALL: mmu_i_data_ok  output  1  one-cycle response pulse.
REQ-008 SHALL: mmu_i_rdata  output  64  [31:0] inst at va, [63:32] inst at va+4.
REQ-009 SHALL: mmu_i_tlbr / mmu_i_pif / mmu_i_ppi  output  1 each  fetch exception flags (combinational on mmu_i_addr and CSR inputs, independent of mmu_i_req).
REQ-010 SHALL: csr_da, csr_pg  input  1 each  CRMD direct / paged mode.
REQ-011 SHALL: csr_plv  input  2  current privilege level.
REQ-012 SHALL: csr_dmw0, csr_dmw1  input  32 each  [31:29] vseg, [27:25] pseg, [3:0] PLV3..PLV0 enables.
REQ-013 SHALL: ibus_req, ibus_addr[31:0]  output  downstream 32-bit word read request, physical address.
REQ-014 SHALL: ibus_addr_ok, ibus_data_ok, ibus_rdata[31:0]  input  downstream accept, response pulse, data.

Function
REQ-015 SHALL translate: csr_da=1 -> pa=va; else (paged) first of dmw0, dmw1 with vseg==va[31:29] and PLV-enable bit [csr_plv] set -> pa={pseg,va[28:0]}.
REQ-016 SHALL: paged, no window vseg matches -> mmu_i_tlbr=1; vseg matches but no matching window enables csr_plv -> mmu_i_ppi=1; mmu_i_pif constant 0; at most one flag high; da mode -> all flags 0.
REQ-017 SHALL drive mmu_i_double = !mmu_i_addr[2] (8-byte aligned pair).
REQ-018 SHALL: FSM states IDLE, A0, D0, A1, D1, RESP.
REQ-019 SHALL: mmu_i_addr_ok = (IDLE or RESP) and no exception flag high; accept = mmu_i_req && mmu_i_addr_ok; requests with any exception flag never accepted.
REQ-020 SHALL on accept latch pa, double, goto A0; clear rdata[63:32] to 0 when single.
REQ-021 SHALL: A0 drives ibus_req=1, ibus_addr=pa; ibus_addr_ok -> D0.
REQ-022 SHALL: D0 on ibus_data_ok capture rdata[31:0]; double -> A1, else -> RESP.
REQ-023 SHALL: A1 drives ibus_req=1, ibus_addr=pa+4; ibus_addr_ok -> D1; D1 on ibus_data_ok capture rdata[63:32] -> RESP.
REQ-024 SHALL: RESP asserts mmu_i_data_ok=1 for exactly one cycle, rdata stable that cycle; next state A0 if accept same cycle, else IDLE.
REQ-025 SHALL keep at most one fetch outstanding; every accepted request receives exactly one data_ok, in order; requester-side cancellation does not abort the bus sequence.
REQ-026 SHALL ignore ibus_data_ok in IDLE, A0, A1, RESP; ibus_req=0 outside A0/A1.
REQ-027 SHALL: latency with zero-wait bus (addr_ok same cycle, data_ok next cycle): single accept at T -> data_ok at T+3; double -> T+5.
REQ-028 SHALL: pa+4 computed modulo 2^32.

Reset
REQ-029 SHALL on resetn=0 immediately: state IDLE, mmu_i_data_ok=0, mmu_i_rdata=0, ibus_req=0, latched pa/double=0.
REQ-030 SHALL: reset mid-transaction abandons it; late ibus_data_ok after reset release ignored (state IDLE).

Verification
REQ-031 SHALL: da=1, addr=0x1c000000, req, zero-wait bus words 0x11111111/0x22222222 -> double=1, ibus_addr 0x1c000000 then 0x1c000004, data_ok at T+5, rdata=0x22222222_11111111.
REQ-032 SHALL: da=1, addr=0x1c000004 -> double=0, one ibus beat, data_ok at T+3, rdata[63:32]=0.
REQ-033 SHALL: pg=1, plv=0, dmw0=0xa0000001, addr=0xa0001000 -> ibus_addr 0x00001000; dmw0=0xa0000008 same addr -> ppi=1, addr_ok=0; addr=0x40000000 -> tlbr=1.
REQ-034 SHALL: req held high back-to-back -> second accept in RESP cycle of first, data_ok pulses in order, no idle cycle between.
REQ-035 SHALL: ibus_addr_ok held low 4 cycles in A0 -> ibus_req/addr stable, data_ok delayed 4 cycles.
REQ-036 SHALL: resetn low during D1 -> outputs zero immediately; stray ibus_data_ok after release produces no mmu_i_data_ok.
